// File: rtl/octa16_pkg.sv
// Shared definitions for the Octa16 add/subtract sequencer: op codes, FSM states,
// flag bit positions and the byte carry-out helper.
package octa16_pkg;

  localparam int W_BYTE = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // adder_8 has no carry-out port; recover it from the MSB inputs and sum bit.
  function automatic logic carry_out(input logic a7, input logic b7, input logic s7);
    return (a7 & b7) | ((a7 | b7) & ~s7);
  endfunction

endpackage

// File: rtl/adder_8.sv
// Combinational 8-bit adder with carry-in; carry-out is derived by the caller.
module adder_8
  import octa16_pkg::*;
(
  input  logic [W_BYTE-1:0] a_i,
  input  logic [W_BYTE-1:0] b_i,
  input  logic              cin_i,
  output logic [W_BYTE-1:0] sum_o
);

  assign sum_o = a_i + b_i + {{(W_BYTE-1){1'b0}}, cin_i};

endmodule

// File: rtl/add16_seq.sv
// 16-bit add/subtract sequencer: one shared adder_8 used for a low-byte pass
// followed by a high-byte pass, producing {C,Z,V,N} and a persistent carry flag.
module add16_seq
  import octa16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        carry_flag,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // The request side is ready only in IDLE; the response is held in DONE until taken.

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;        // second operand, already inverted for SUB/SBC
  logic        cin_q, cin_d;    // cin0 during LO, then the inter-byte carry c8
  logic [7:0]  sum_lo_q, sum_lo_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        carry_q, carry_d;

  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cout;
  logic [15:0] full_sum;
  logic        accept;

  assign req_ready   = (state_q == ST_IDLE) & rst_n;
  assign accept      = req_valid & req_ready;
  assign rsp_valid   = (state_q == ST_DONE);
  assign rsp_result  = result_q;
  assign rsp_flags   = flags_q;
  assign carry_flag  = carry_q;
  assign dbg_state_o = state_q;

  // Adder inputs come only from registers, so req_* never reaches rsp_* combinationally.
  assign add_a    = (state_q == ST_HI) ? a_q[15:8] : a_q[7:0];
  assign add_b    = (state_q == ST_HI) ? b_q[15:8] : b_q[7:0];
  assign add_cout = carry_out(add_a[7], add_b[7], add_sum[7]);
  assign full_sum = {add_sum, sum_lo_q};

  adder_8 u_adder (
    .a_i  (add_a),
    .b_i  (add_b),
    .cin_i(cin_q),
    .sum_o(add_sum)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    sum_lo_d = sum_lo_q;
    result_d = result_q;
    flags_d  = flags_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LO;
          a_d     = req_a;
          b_d     = req_op[0] ? ~req_b : req_b;
          case (req_op)
            OP_ADD:  cin_d = 1'b0;
            OP_SUB:  cin_d = 1'b1;
            default: cin_d = carry_q;
          endcase
        end
      end
      ST_LO: begin
        state_d  = ST_HI;
        sum_lo_d = add_sum;
        cin_d    = add_cout;
      end
      ST_HI: begin
        state_d         = ST_DONE;
        result_d        = full_sum;
        flags_d[FLAG_C] = add_cout;
        flags_d[FLAG_Z] = (full_sum == 16'h0000);
        flags_d[FLAG_V] = (a_q[15] == b_q[15]) & (full_sum[15] != a_q[15]);
        flags_d[FLAG_N] = full_sum[15];
        carry_d         = add_cout;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_lo_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sum_lo_q <= sum_lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      carry_q  <= carry_d;
    end
  end

endmodule

// File: tb/tb_add16_seq.sv
// Directed self-checking bench for add16_seq: arithmetic and flags, carry chaining,
// latency, back-pressure and reset during an operation.
module tb_add16_seq;
  import octa16_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        carry_flag;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  add16_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .carry_flag (carry_flag),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a request, complete the handshake, scramble req_* afterwards,
  // then wait (bounded) for rsp_valid. lat counts falling edges after the handshake edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [15:0] r, output logic [3:0] f,
                       output logic c);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom_range(0, 3));
    req_a  = 16'($urandom_range(0, 65535));
    req_b  = 16'($urandom_range(0, 65535));
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    r = rsp_result; f = rsp_flags; c = carry_flag;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_result !== 16'h0000) begin n_bad++; $display("FAIL rst_result got=%h exp=0000", rsp_result); end
    n_cmp++; if (rsp_flags !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got=%b exp=0000", rsp_flags); end
    n_cmp++; if (carry_flag !== 1'b0) begin n_bad++; $display("FAIL rst_carry got=%b exp=0", carry_flag); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rel_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_add_latency();
    int lat; logic [15:0] r; logic [3:0] f; logic c;
    issue(OP_ADD, 16'h00FF, 16'h0001, lat, r, f, c);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL add_latency got=%0d exp=3", lat); end
    n_cmp++; if (r !== 16'h0100) begin n_bad++; $display("FAIL add_result got=%h exp=0100", r); end
    n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL add_flags got=%b exp=0000", f); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL add_carry got=%b exp=0", c); end
    release_rsp();
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL add_return_idle got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_carry_chain();
    int lat; logic [15:0] r; logic [3:0] f; logic c;
    issue(OP_ADD, 16'hFFFF, 16'h0001, lat, r, f, c);
    n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL wrap_result got=%h exp=0000", r); end
    n_cmp++; if (f !== 4'b1100) begin n_bad++; $display("FAIL wrap_flags got=%b exp=1100", f); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL wrap_carry got=%b exp=1", c); end
    release_rsp();
    issue(OP_ADC, 16'h0000, 16'h0000, lat, r, f, c);
    n_cmp++; if (r !== 16'h0001) begin n_bad++; $display("FAIL adc_result got=%h exp=0001", r); end
    n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL adc_flags got=%b exp=0000", f); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL adc_carry got=%b exp=0", c); end
    release_rsp();
  endtask

  task automatic test_sub();
    int lat; logic [15:0] r; logic [3:0] f; logic c;
    issue(OP_SUB, 16'h8000, 16'h0001, lat, r, f, c);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sub_latency got=%0d exp=3", lat); end
    n_cmp++; if (r !== 16'h7FFF) begin n_bad++; $display("FAIL sub_ovf_result got=%h exp=7fff", r); end
    n_cmp++; if (f !== 4'b1010) begin n_bad++; $display("FAIL sub_ovf_flags got=%b exp=1010", f); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL sub_ovf_carry got=%b exp=1", c); end
    release_rsp();
  endtask

  task automatic test_sbc();
    int lat; logic [15:0] r; logic [3:0] f; logic c;
    issue(OP_SUB, 16'h0001, 16'h0002, lat, r, f, c);
    n_cmp++; if (r !== 16'hFFFF) begin n_bad++; $display("FAIL sub_neg_result got=%h exp=ffff", r); end
    n_cmp++; if (f !== 4'b0001) begin n_bad++; $display("FAIL sub_neg_flags got=%b exp=0001", f); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL sub_neg_carry got=%b exp=0", c); end
    release_rsp();
    issue(OP_SBC, 16'h0005, 16'h0001, lat, r, f, c);
    n_cmp++; if (r !== 16'h0003) begin n_bad++; $display("FAIL sbc_result got=%h exp=0003", r); end
    n_cmp++; if (f !== 4'b1000) begin n_bad++; $display("FAIL sbc_flags got=%b exp=1000", f); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL sbc_carry got=%b exp=1", c); end
    release_rsp();
  endtask

  task automatic test_back_pressure();
    int lat; logic [15:0] r; logic [3:0] f; logic c;
    logic stable;
    issue(OP_ADD, 16'h1234, 16'h1111, lat, r, f, c);
    n_cmp++; if (r !== 16'h2345 || f !== 4'b0000) begin
      n_bad++; $display("FAIL bp_first got=%h/%b exp=2345/0000", r, f);
    end
    req_valid = 1'b1; req_op = OP_SUB; req_a = 16'h0010; req_b = 16'h0001;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h2345 || rsp_flags !== 4'b0000 ||
          req_ready !== 1'b0 || dbg_state !== 2'd3) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin
      n_bad++; $display("FAIL bp_hold got valid=%b res=%h flags=%b ready=%b st=%0d exp 1/2345/0000/0/3",
                        rsp_valid, rsp_result, rsp_flags, req_ready, dbg_state);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++; if (dbg_state !== 2'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_idle got st=%0d valid=%b ready=%b exp st=0 valid=0 ready=1",
                        dbg_state, rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL bp_accept got st=%0d exp=1", dbg_state); end
    repeat (2) @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h000F || rsp_flags !== 4'b1000) begin
      n_bad++; $display("FAIL bp_second got valid=%b res=%h flags=%b exp 1/000f/1000",
                        rsp_valid, rsp_result, rsp_flags);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    n_cmp++; if (carry_flag !== 1'b1) begin n_bad++; $display("FAIL mid_pre_carry got=%b exp=1", carry_flag); end
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_a = 16'hFFFF; req_b = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL mid_in_lo got st=%0d exp=1", dbg_state); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd0 || carry_flag !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset got st=%0d carry=%b ready=%b exp 0/0/0", dbg_state, carry_flag, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready got=%b exp=1", req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp got=%b exp=0", seen); end
    n_cmp++; if (carry_flag !== 1'b0) begin n_bad++; $display("FAIL mid_carry got=%b exp=0", carry_flag); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_add_latency();
    test_carry_chain();
    test_sub();
    test_sbc();
    test_back_pressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
